// File: rtl/divider_control_datapath_if.sv
// Switch/key front-end bundle for the sequential divider.
// master: switch/key side (drives Din, ClearA_LoadB, Run; observes results).
// slave : divider side (samples operands/keys; drives Quotient, Remainder,
//         Divisor, Busy, Done, DivZero).
interface divider_control_datapath_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] Din;
  logic             ClearA_LoadB;  // active-low
  logic             Run;           // active-low
  logic [WIDTH-1:0] Quotient;
  logic [WIDTH-1:0] Remainder;
  logic [WIDTH-1:0] Divisor;
  logic             Busy;
  logic             Done;
  logic             DivZero;

  modport master (
    output Din, ClearA_LoadB, Run,
    input  Quotient, Remainder, Divisor, Busy, Done, DivZero
  );

  modport slave (
    input  Din, ClearA_LoadB, Run,
    output Quotient, Remainder, Divisor, Busy, Done, DivZero
  );
endinterface

// File: rtl/divider_control_datapath.sv
// Sequential unsigned restoring divider (one shift and one subtract state per bit).
// Ports:
//   Clk     - system clock, rising edge
//   Reset_n - asynchronous active-low reset
//   bus     - slave side of divider_control_datapath_if:
//             Din, ClearA_LoadB (active-low load divisor), Run (active-low start)
//             in; Quotient, Remainder, Divisor, Busy, Done, DivZero out.
// All outputs come straight from flops; nothing combinational from inputs.
module divider_control_datapath #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                        Clk,
  input  logic                        Reset_n,
  divider_control_datapath_if.slave   bus
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned RW    = WIDTH + 1;  // partial remainder width
  localparam int unsigned TW    = WIDTH + 2;  // trial subtraction width

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_SHIFT,
    S_SUB,
    S_DONE
  } state_t;

  state_t              state_q;
  logic [WIDTH-1:0]    q_q;
  logic [RW-1:0]       r_q;
  logic [WIDTH-1:0]    d_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                divzero_q;
  logic                busy_q;
  logic                done_q;

  // Trial subtract; the MSB is the borrow.
  logic [TW-1:0]       trial_c;
  logic                borrow_c;

  assign trial_c  = TW'({1'b0, r_q}) - TW'({2'b00, d_q});
  assign borrow_c = trial_c[TW-1];

  // Control and datapath in one block; Busy/Done are registered alongside state.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= S_IDLE;
      q_q       <= '0;
      r_q       <= '0;
      d_q       <= '0;
      cnt_q     <= '0;
      divzero_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // Load key wins over Run when both are pressed.
          if (!bus.ClearA_LoadB) begin
            state_q <= S_LOAD;
          end else if (!bus.Run) begin
            state_q <= S_START;
            busy_q  <= 1'b1;
          end
        end
        S_LOAD: begin
          d_q     <= bus.Din;
          r_q     <= '0;
          state_q <= S_IDLE;
        end
        S_START: begin
          q_q       <= bus.Din;
          r_q       <= '0;
          cnt_q     <= '0;
          divzero_q <= (d_q == '0);
          state_q   <= S_SHIFT;
        end
        S_SHIFT: begin
          {r_q, q_q} <= {r_q[WIDTH-1:0], q_q, 1'b0};
          state_q    <= S_SUB;
        end
        S_SUB: begin
          if (!borrow_c) begin
            r_q    <= trial_c[RW-1:0];
            q_q[0] <= 1'b1;
          end
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt_q   <= cnt_q + CNT_W'(1);
            state_q <= S_SHIFT;
          end
        end
        S_DONE: begin
          // Wait for key release so a held Run never restarts.
          if (bus.Run) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Quotient  = q_q;
  assign bus.Remainder = r_q[WIDTH-1:0];
  assign bus.Divisor   = d_q;
  assign bus.Busy      = busy_q;
  assign bus.Done      = done_q;
  assign bus.DivZero   = divzero_q;

endmodule
